// File: rtl/pulse_stretch_arb_pkg.sv
// Shared types and constants for the pulse stretcher arbiter.
package pulse_arb_pkg;

    // Controller states: waiting for a request, or driving a pulse.
    typedef enum logic {
        IDLE  = 1'b0,
        PULSE = 1'b1
    } state_e;

    // Default width of the pulse-length configuration input.
    localparam int W_W_DEFAULT = 4;

    // Channel-index width; at least one bit even for degenerate counts.
    function automatic int ch_width(input int n_ch);
        return (n_ch <= 1) ? 1 : $clog2(n_ch);
    endfunction

endpackage

// File: rtl/pulse_stretch_arb_rr_pick.sv
// Combinational round-robin selector: lowest requesting index at or
// above ptr, wrapping around to index 0.
module rr_pick
    import pulse_arb_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int CH_W = ch_width(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    output logic            valid,
    output logic [CH_W-1:0] g
);

    logic [2*N_CH-1:0] req_dbl;
    logic [N_CH-1:0]   req_rot;
    logic [CH_W-1:0]   off;
    logic [CH_W:0]     sum;

    // Rotate requests so that bit 0 corresponds to the channel at ptr.
    assign req_dbl = {req, req} >> ptr;
    assign req_rot = req_dbl[N_CH-1:0];

    // Pick the smallest rotated offset, then map it back to a channel index.
    always_comb begin
        valid = 1'b0;
        off   = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                valid = 1'b1;
                off   = CH_W'(i);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (CH_W + 1)'(N_CH)) begin
            sum = sum - (CH_W + 1)'(N_CH);
        end
        g = sum[CH_W-1:0];
    end

endmodule

// File: rtl/pulse_stretch_arb.sv
// Round-robin scheduler sharing one programmable pulse stretcher among
// N_CH rising-edge trigger inputs.
module pulse_stretch_arb
    import pulse_arb_pkg::*;
#(
    parameter  int N_CH = 4,
    parameter  int W_W  = W_W_DEFAULT,
    localparam int CH_W = ch_width(N_CH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] din,
    input  logic [W_W-1:0]  width_cfg,
    input  logic            ovf_clr,
    output logic            dout,
    output logic [CH_W-1:0] dout_ch,
    output logic            busy,
    output logic [N_CH-1:0] pend,
    output logic [N_CH-1:0] ovf
);

    logic [N_CH-1:0] din_q;
    logic [N_CH-1:0] pend_q, pend_d;
    logic [N_CH-1:0] ovf_q, ovf_d;
    state_e          state_q, state_d;
    logic [W_W-1:0]  cnt_q, cnt_d;
    logic [CH_W-1:0] ptr_q, ptr_d;
    logic            dout_q, dout_d;
    logic [CH_W-1:0] dout_ch_q, dout_ch_d;

    logic [N_CH-1:0] rise;
    logic            pick_valid;
    logic [CH_W-1:0] pick_g;
    logic            grant;

    assign rise = din & ~din_q;

    rr_pick #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_rr_pick (
        .req   (pend_q),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .g     (pick_g)
    );

    // Arbitration only happens while idle; PULSE ignores the queue.
    assign grant = (state_q == IDLE) && pick_valid;

    // Request queue: the granted bit clears, a fresh rise always re-queues.
    // A rise on an already-pending channel that is not being granted merges
    // and is flagged; a set beats a simultaneous clear strobe.
    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q;
        for (int i = 0; i < N_CH; i++) begin
            if (grant && (pick_g == CH_W'(i))) begin
                pend_d[i] = rise[i];
            end else begin
                pend_d[i] = pend_q[i] | rise[i];
                if (ovf_clr) begin
                    ovf_d[i] = 1'b0;
                end
                if (rise[i] && pend_q[i]) begin
                    ovf_d[i] = 1'b1;
                end
            end
            if (grant && (pick_g == CH_W'(i)) && ovf_clr) begin
                ovf_d[i] = 1'b0;
            end
        end
    end

    // Controller: grant from IDLE, count the pulse down in PULSE.
    // cnt holds the remaining high cycles after the current one.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        dout_d    = dout_q;
        dout_ch_d = dout_ch_q;
        case (state_q)
            IDLE: begin
                dout_d = 1'b0;
                if (pick_valid) begin
                    state_d   = PULSE;
                    dout_d    = 1'b1;
                    dout_ch_d = pick_g;
                    cnt_d     = (width_cfg == '0) ? '0 : (width_cfg - 1'b1);
                    ptr_d     = (pick_g == CH_W'(N_CH - 1)) ? '0 : (pick_g + 1'b1);
                end
            end
            PULSE: begin
                if (cnt_q != '0) begin
                    cnt_d  = cnt_q - 1'b1;
                    dout_d = 1'b1;
                end else begin
                    dout_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                dout_d  = 1'b0;
            end
        endcase
    end

    // All state registers, with synchronous reset discarding any queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            din_q     <= '0;
            pend_q    <= '0;
            ovf_q     <= '0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            ptr_q     <= '0;
            dout_q    <= 1'b0;
            dout_ch_q <= '0;
        end else begin
            din_q     <= din;
            pend_q    <= pend_d;
            ovf_q     <= ovf_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            dout_q    <= dout_d;
            dout_ch_q <= dout_ch_d;
        end
    end

    assign dout    = dout_q;
    assign dout_ch = dout_ch_q;
    assign busy    = (state_q == PULSE);
    assign pend    = pend_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_pulse_stretch_arb.sv
// Directed bench for pulse_stretch_arb (N_CH=4, W_W=4).
module tb_pulse_stretch_arb;

    logic       clk;
    logic       rst;
    logic [3:0] din;
    logic [3:0] width_cfg;
    logic       ovf_clr;
    logic       dout;
    logic [1:0] dout_ch;
    logic       busy;
    logic [3:0] pend;
    logic [3:0] ovf;

    int checks   = 0;
    int failures = 0;
    int n;

    pulse_stretch_arb #(
        .N_CH (4),
        .W_W  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .width_cfg (width_cfg),
        .ovf_clr   (ovf_clr),
        .dout      (dout),
        .dout_ch   (dout_ch),
        .busy      (busy),
        .pend      (pend),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge; inputs are driven and outputs sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [1:0] exp_ch [4];

        rst = 1'b1; din = 4'b0000; width_cfg = 4'd3; ovf_clr = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_dout",    32'(dout),    0);
        chk("rst_dout_ch", 32'(dout_ch), 0);
        chk("rst_busy",    32'(busy),    0);
        chk("rst_pend",    32'(pend),    0);
        chk("rst_ovf",     32'(ovf),     0);

        // Single request on ch2, width 3
        din = 4'b0100; tick();
        chk("t1_pend_set", 32'(pend), 32'h4);
        chk("t1_dout_pre", 32'(dout), 0);
        din = 4'b0000; tick();
        chk("t1_dout_c1", 32'(dout), 1);
        chk("t1_ch",      32'(dout_ch), 2);
        chk("t1_busy",    32'(busy), 1);
        chk("t1_pend_clr", 32'(pend), 0);
        tick(); chk("t1_dout_c2", 32'(dout), 1);
        tick(); chk("t1_dout_c3", 32'(dout), 1);
        tick(); chk("t1_dout_end", 32'(dout), 0);
        chk("t1_busy_end", 32'(busy), 0);
        $display("t1 single request ch2 width3 done");

        // Simultaneous rises on ch0, ch1, ch3 from ptr 0, width 2
        rst = 1'b1; tick(); rst = 1'b0;
        width_cfg = 4'd2;
        din = 4'b1011; tick();
        chk("t2_pend", 32'(pend), 32'hB);
        din = 4'b0000;
        exp_ch[0] = 2'd0; exp_ch[1] = 2'd1; exp_ch[2] = 2'd3;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t2_dout_c1", 32'(dout), 1);
            chk("t2_ch", 32'(dout_ch), 32'(exp_ch[k]));
            tick(); chk("t2_dout_c2", 32'(dout), 1);
            tick(); chk("t2_gap", 32'(dout), 0);
            $display("t2 pulse %0d on ch%0d", k, dout_ch);
        end
        chk("t2_pend_empty", 32'(pend), 0);

        // Fairness: ch0/ch1 re-raised after each grant; also proves ptr wrapped to 0
        din = 4'b0011; tick();
        din = 4'b0000;
        chk("t3_pend", 32'(pend), 32'h3);
        exp_ch[0] = 2'd0; exp_ch[1] = 2'd1; exp_ch[2] = 2'd0; exp_ch[3] = 2'd1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t3_dout", 32'(dout), 1);
            chk("t3_ch", 32'(dout_ch), 32'(exp_ch[k]));
            if (k < 2) din = 4'b0001 << exp_ch[k];
            tick(); din = 4'b0000;
            tick(); chk("t3_gap", 32'(dout), 0);
            $display("t3 grant %0d on ch%0d", k, exp_ch[k]);
        end
        chk("t3_pend_empty", 32'(pend), 0);

        // Overflow: two ch1 rises during a width-8 ch0 pulse
        width_cfg = 4'd8;
        din = 4'b0001; tick(); din = 4'b0000; tick();
        chk("t4_dout_ch0", 32'(dout), 1);
        chk("t4_ch0", 32'(dout_ch), 0);
        din = 4'b0010; tick(); din = 4'b0000; tick();
        din = 4'b0010; tick(); din = 4'b0000; tick();
        chk("t4_ovf_set", 32'(ovf), 32'h2);
        chk("t4_pend1", 32'(pend), 32'h2);
        chk("t4_still_high", 32'(dout), 1);
        chk("t4_still_ch0", 32'(dout_ch), 0);
        repeat (4) tick();
        chk("t4_ch0_end", 32'(dout), 0);
        tick();
        chk("t4_ch1_dout", 32'(dout), 1);
        chk("t4_ch1", 32'(dout_ch), 1);
        chk("t4_pend_clr", 32'(pend), 0);
        n = 1;
        for (int j = 0; j < 20; j++) begin
            tick();
            if (dout) n++;
            else break;
        end
        chk("t4_ch1_width", 32'(n), 8);
        repeat (3) tick();
        chk("t4_single_pulse", 32'(dout), 0);
        chk("t4_pend_idle", 32'(pend), 0);
        chk("t4_ovf_sticky", 32'(ovf), 32'h2);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        chk("t4_ovf_clr", 32'(ovf), 0);
        $display("t4 overflow merge and clear done");

        // ovf_clr coincident with a new overflow: set wins
        width_cfg = 4'd4;
        din = 4'b0001; tick(); din = 4'b0000; tick();
        chk("t4b_dout", 32'(dout), 1);
        din = 4'b0010; tick(); din = 4'b0000; tick();
        din = 4'b0010; ovf_clr = 1'b1; tick(); din = 4'b0000; ovf_clr = 1'b0;
        chk("t4b_set_wins", 32'(ovf), 32'h2);
        repeat (12) tick();
        chk("t4b_idle", 32'(busy), 0);
        chk("t4b_pend", 32'(pend), 0);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        chk("t4b_ovf_clr", 32'(ovf), 0);
        $display("t4b coincident clear/set done");

        // width 0 acts as 1; width change mid-pulse only affects the next pulse
        width_cfg = 4'd0;
        din = 4'b0100; tick(); din = 4'b0000; tick();
        chk("t5_w0_dout", 32'(dout), 1);
        chk("t5_w0_ch", 32'(dout_ch), 2);
        tick(); chk("t5_w0_end", 32'(dout), 0);
        width_cfg = 4'd2;
        din = 4'b1000; tick(); din = 4'b0000; tick();
        chk("t5_w2_dout", 32'(dout), 1);
        chk("t5_w2_ch", 32'(dout_ch), 3);
        width_cfg = 4'd9;
        din = 4'b1000; tick(); din = 4'b0000;
        chk("t5_w2_c2", 32'(dout), 1);
        tick(); chk("t5_w2_end", 32'(dout), 0);
        tick();
        chk("t5_w9_dout", 32'(dout), 1);
        chk("t5_w9_ch", 32'(dout_ch), 3);
        n = 1;
        for (int j = 0; j < 20; j++) begin
            tick();
            if (dout) n++;
            else break;
        end
        chk("t5_w9_width", 32'(n), 9);
        $display("t5 width handling done");

        // Reset mid-pulse with ch1 and ch3 queued
        width_cfg = 4'd5;
        din = 4'b0001; tick(); din = 4'b0000; tick();
        chk("t6_dout", 32'(dout), 1);
        din = 4'b1010; tick(); din = 4'b0000;
        chk("t6_pend", 32'(pend), 32'hA);
        chk("t6_dout_pre", 32'(dout), 1);
        rst = 1'b1; tick();
        chk("t6_rst_dout", 32'(dout), 0);
        chk("t6_rst_pend", 32'(pend), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        rst = 1'b0;
        repeat (5) tick();
        chk("t6_quiet_dout", 32'(dout), 0);
        chk("t6_quiet_pend", 32'(pend), 0);
        $display("t6 reset mid-pulse done");

        // din held high through reset gives exactly one request
        din = 4'b0100; rst = 1'b1; tick(); tick(); rst = 1'b0;
        chk("t7_pend_rst", 32'(pend), 0);
        tick();
        chk("t7_pend_one", 32'(pend), 32'h4);
        chk("t7_dout_pre", 32'(dout), 0);
        tick();
        chk("t7_dout", 32'(dout), 1);
        chk("t7_ch", 32'(dout_ch), 2);
        repeat (5) tick();
        chk("t7_end", 32'(dout), 0);
        repeat (3) tick();
        chk("t7_no_repeat", 32'(dout), 0);
        chk("t7_pend_empty", 32'(pend), 0);
        din = 4'b0000;
        $display("t7 din high through reset done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
